// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shift-add unsigned multiply and
// optional restoring unsigned divide (define ALU_MC_DIV_EN), with valid/ready on both sides.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             sign,
  output logic             err
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_MULLO = 4'd8;
  localparam logic [3:0] OP_MULHI = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;
  localparam logic [3:0] OP_REMU  = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [1:0]         iter_sel;
  logic               iter_err;

  logic [WIDTH-1:0]   sc_res;
  logic               sc_err;
  logic               is_div;
  logic               is_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   fin_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef ALU_MC_DIV_EN
  assign is_div = (op == OP_DIVU) || (op == OP_REMU);
`else
  assign is_div = 1'b0;
`endif
  assign is_iter = (op == OP_MULLO) || (op == OP_MULHI) || is_div;

  always_comb begin : single_cycle
    // NOTE: defaults first so no path through the case leaves a latch behind.
    sc_res = '0;
    sc_err = 1'b0;
    case (op)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a + ~b + WIDTH'(1);
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_SLT:  sc_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: sc_res = WIDTH'(a < b);
      OP_MULLO, OP_MULHI: begin
      end
`ifdef ALU_MC_DIV_EN
      OP_DIVU, OP_REMU: begin
      end
`endif
      default: sc_err = 1'b1;
    endcase
  end

`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0] div_sh;
  logic [WIDTH:0] div_diff;
`endif

  // acc holds {partial product, multiplier} for mul, {remainder, quotient} for div.
  always_comb begin : iter_step
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    acc_nxt = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    div_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, opnd};
    if (iter_sel[1]) begin
      // Explicit compare: with a zero divisor div_sh may exceed WIDTH bits.
      if (div_sh >= {1'b0, opnd}) acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                        acc_nxt = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
`endif
    fin_res = iter_sel[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking everywhere here; every register, datapath included, is reset.
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      iter_sel <= '0;
      iter_err <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      sign     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_iter) begin
              state    <= BUSY;
              cnt      <= '0;
              iter_sel <= op[1:0];
              acc      <= {{WIDTH{1'b0}}, (is_div ? a : b)};
              opnd     <= is_div ? b : a;
              iter_err <= is_div && (b == '0);
            end else begin
              state  <= DONE;
              result <= sc_res;
              zero   <= (sc_res == '0);
              sign   <= sc_res[WIDTH-1];
              err    <= sc_err;
            end
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state  <= DONE;
            result <= fin_res;
            zero   <= (fin_res == '0);
            sign   <= fin_res[WIDTH-1];
            err    <= iter_err;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus randomized ops with
// random backpressure, compared every cycle against a behavioural model.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         sign;
  logic         err;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .sign(sign), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           acc_cyc;
    bit           seen;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rnd_mode = 1'b0;
  bit   post_xfer = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected outcome straight from the op table, using plain arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    e.res = '0; e.err = 1'b0; e.lat = 1; e.acc_cyc = 0; e.seen = 1'b0;
    case (o)
      4'd0: e.res = x + y;
      4'd1: e.res = x - y;
      4'd2: e.res = x & y;
      4'd3: e.res = x | y;
      4'd4: e.res = x ^ y;
      4'd5: e.res = ~(x | y);
      4'd6: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      4'd7: e.res = (x < y) ? W'(1) : W'(0);
      4'd8: begin e.res = p[W-1:0];   e.lat = W + 1; end
      4'd9: begin e.res = p[2*W-1:W]; e.lat = W + 1; end
`ifdef ALU_MC_DIV_EN
      4'd10: begin
        e.lat = W + 1;
        if (y == 0) begin e.res = '1; e.err = 1'b1; end
        else e.res = x / y;
      end
      4'd11: begin
        e.lat = W + 1;
        if (y == 0) begin e.res = x; e.err = 1'b1; end
        else e.res = x % y;
      end
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Single compare process: checks outputs on every falling edge.
  always @(negedge clk) begin
    if (reset) begin
      post_xfer = 1'b0;
    end else begin
      if (post_xfer) begin
        check(!out_valid, "valid_after_xfer", out_valid, 0);
        check(in_ready, "ready_after_xfer", in_ready, 1);
        post_xfer = 1'b0;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_out_valid", result, 0);
        end else begin
          if (!exp_q[0].seen) begin
            check(cyc - exp_q[0].acc_cyc == exp_q[0].lat - 1, "latency",
                  cyc - exp_q[0].acc_cyc + 1, exp_q[0].lat);
            exp_q[0].seen = 1'b1;
          end
          check(result == exp_q[0].res, "result", result, exp_q[0].res);
          check(zero == (exp_q[0].res == '0), "zero", zero, exp_q[0].res == '0);
          check(sign == exp_q[0].res[W-1], "sign", sign, exp_q[0].res[W-1]);
          check(err == exp_q[0].err, "err", err, exp_q[0].err);
          check(!in_ready, "ready_while_valid", in_ready, 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            post_xfer = 1'b1;
          end
        end
      end else if (exp_q.size() != 0) begin
        check(!in_ready, "ready_while_busy", in_ready, 0);
        if (cyc - exp_q[0].acc_cyc > 3 * W) begin
          check(1'b0, "result_timeout", cyc - exp_q[0].acc_cyc, exp_q[0].lat);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int   guard = 0;
    exp_t e;
    while (!in_ready && guard < 200) begin
      if (rnd_mode) begin
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid  = 1'($urandom_range(0, 1));
        op        = 4'($urandom);
        a         = $urandom;
        b         = $urandom;
      end
      tick();
      guard++;
    end
    if (!in_ready) begin
      check(1'b0, "issue_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1; op = o; a = x; b = y;
    tick();
    e = model(o, x, y);
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || !in_ready) && guard < 200) begin
      tick();
      guard++;
    end
    check(exp_q.size() == 0 && in_ready, "drain", exp_q.size(), 0);
  endtask

  // Pins the model to hand-computed values, then runs the op through the DUT.
  task automatic run_lit(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] res, input logic e_err, input int lat);
    exp_t e;
    e = model(o, x, y);
    check(e.res == res, "model_res", e.res, res);
    check(e.err == e_err, "model_err", e.err, e_err);
    check(e.lat == lat, "model_lat", e.lat, lat);
    issue(o, x, y);
    wait_idle();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'(1);
      3: return {1'b1, {(W-1){1'b0}}};
      4: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int guard;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check(in_ready, "rst_in_ready", in_ready, 1);
    check(!out_valid, "rst_out_valid", out_valid, 0);
    check(result == '0, "rst_result", result, 0);
    check(zero, "rst_zero", zero, 1);
    check(!sign, "rst_sign", sign, 0);
    check(!err, "rst_err", err, 0);

    out_ready = 1'b1;
    run_lit(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    run_lit(4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    run_lit(4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    run_lit(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    run_lit(4'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    run_lit(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
    run_lit(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    run_lit(4'd13, 32'd3, 32'd4, 32'd0, 1'b1, 1);
`ifdef ALU_MC_DIV_EN
    run_lit(4'd10, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    run_lit(4'd11, 32'd100, 32'd7, 32'd2, 1'b0, 33);
    run_lit(4'd10, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1, 33);
    run_lit(4'd11, 32'd9, 32'd0, 32'd9, 1'b1, 33);
`else
    run_lit(4'd10, 32'd100, 32'd7, 32'd0, 1'b1, 1);
    run_lit(4'd11, 32'd100, 32'd7, 32'd0, 1'b1, 1);
`endif

    // Backpressure: result held for 5 cycles while a new request is offered.
    out_ready = 1'b0;
    issue(4'd0, 32'd10, 32'd20);
    guard = 0;
    while (!out_valid && guard < 50) begin tick(); guard++; end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 4'd1; a = $urandom; b = $urandom;
      tick();
      check(out_valid, "bp_out_valid", out_valid, 1);
      check(!in_ready, "bp_in_ready_low", in_ready, 0);
      check(result == 32'd30, "bp_result", result, 30);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check(!out_valid, "bp_valid_drop", out_valid, 0);
    check(in_ready, "bp_in_ready_high", in_ready, 1);
    wait_idle();

    // Reset in the middle of a multiply, after 10 iterations.
    issue(4'd8, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (10) tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    check(in_ready, "midrst_in_ready", in_ready, 1);
    check(!out_valid, "midrst_out_valid", out_valid, 0);
    check(result == '0, "midrst_result", result, 0);
    check(zero && !err, "midrst_flags", {zero, err}, 2'b10);
    run_lit(4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    // Randomized ops with random backpressure and junk requests while busy.
    rnd_mode = 1'b1;
    for (int i = 0; i < 400; i++) issue(4'($urandom), pick(), pick());
    rnd_mode = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
